// File: rtl/alu_driver.sv
//==============================================================================
// Module      : alu_driver
// Description : Command-side driver for a clocked ALU. Accepts one operation
//               at a time on a valid/ready command port, drives the ALU
//               operand/opcode inputs and holds them stable for the ALU
//               latency. It then captures the ALU result and zero flag and
//               returns them with the command tag on a valid/ready response
//               port.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
// Parameters
//   DATA_W     operand / result width (must match the ALU)
//   TAG_W      width of the caller tag echoed on the response
//   ALU_LAT    ALU register stages from operands to result, legal 1..7
//
// Build options
//   ALU_DRV_ZERO_CHECK_EN  when defined, a sticky checker raises flag_err if
//                          the ALU zero flag disagrees with its result on the
//                          capture edge. When undefined, flag_err is tied low.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   cmd_valid / cmd_ready     command handshake
//   cmd_op, cmd_a, cmd_b      operation (ALU opcode encoding) and operands
//   cmd_tag                   caller tag
//   alu_opcode, alu_a, alu_b  registered drive to the ALU inputs
//   alu_out, alu_zero         ALU result and zero flag
//   rsp_valid / rsp_ready     response handshake
//   rsp_data, rsp_zero        captured ALU result and zero flag
//   rsp_tag                   tag of the originating command
//   busy                      high while a command is outstanding
//   done_count                completed response handshakes, modulo 2^16
//   flag_err                  sticky zero-flag consistency error
//==============================================================================
`default_nettype none

module alu_driver #(
    parameter int DATA_W  = 8,
    parameter int TAG_W   = 4,
    parameter int ALU_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    // command port
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic [TAG_W-1:0]  cmd_tag,
    // ALU side
    output logic [2:0]        alu_opcode,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_zero,
    // response port
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_zero,
    output logic [TAG_W-1:0]  rsp_tag,
    // status
    output logic              busy,
    output logic [15:0]       done_count,
    output logic              flag_err
);

    // Opcode encoding shared with the ALU (opcode_t); ADD is encoding 0 and
    // is the value the opcode register returns to on reset.
    localparam logic [2:0] c_OP_ADD   = 3'd0;

    // The wait counter is loaded with the ALU latency and counts down to 0;
    // three bits cover the legal 1..7 range.
    localparam logic [2:0] c_LAT_LOAD = 3'(ALU_LAT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic [2:0] r_wait_cnt;

    // One-cycle strobes decoded by the FSM for the datapath
    logic       w_accept;    // command handshake this cycle
    logic       w_capture;   // ALU result is valid on this edge
    logic       w_rsp_fire;  // response handshake this cycle

    //--------------------------------------------------------------------------
    // FSM state register
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    //--------------------------------------------------------------------------
    // FSM next-state and handshake outputs
    //--------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        cmd_ready    = 1'b0;
        rsp_valid    = 1'b0;
        busy         = 1'b0;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        w_rsp_fire   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_WAIT;
                end
            end

            ST_WAIT: begin
                busy = 1'b1;
                // The counter reaches 0 on the edge the ALU registers its
                // result, so the result is stable on the following edge.
                if (r_wait_cnt == 3'd0) begin
                    w_capture    = 1'b1;
                    w_state_next = ST_RESP;
                end
            end

            ST_RESP: begin
                busy      = 1'b1;
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_rsp_fire   = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    //--------------------------------------------------------------------------
    // Operand drive, wait counter, response capture and completion count.
    // Operands change only on acceptance, so they stay stable for the whole
    // ALU pipeline and through the response phase.
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_opcode <= c_OP_ADD;
            alu_a      <= '0;
            alu_b      <= '0;
            rsp_tag    <= '0;
            rsp_data   <= '0;
            rsp_zero   <= 1'b0;
            r_wait_cnt <= 3'd0;
            done_count <= 16'd0;
        end else begin
            if (w_accept) begin
                alu_opcode <= cmd_op;
                alu_a      <= cmd_a;
                alu_b      <= cmd_b;
                rsp_tag    <= cmd_tag;
                r_wait_cnt <= c_LAT_LOAD;
            end else if ((r_state == ST_WAIT) && (r_wait_cnt != 3'd0)) begin
                r_wait_cnt <= r_wait_cnt - 3'd1;
            end

            if (w_capture) begin
                rsp_data <= alu_out;
                rsp_zero <= alu_zero;
            end

            // Natural 16-bit wrap gives the modulo-2^16 count.
            if (w_rsp_fire) begin
                done_count <= done_count + 16'd1;
            end
        end
    end

    //--------------------------------------------------------------------------
    // Zero-flag consistency checker
    //--------------------------------------------------------------------------
`ifdef ALU_DRV_ZERO_CHECK_EN
    logic r_flag_err;

    // Sticky until reset. The response itself is delivered unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_flag_err <= 1'b0;
        end else if (w_capture && (alu_zero != (alu_out == '0))) begin
            r_flag_err <= 1'b1;
        end
    end

    assign flag_err = r_flag_err;
`else
    assign flag_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_driver.sv
//==============================================================================
// Module      : tb_alu_driver
// Description : Self-checking bench for alu_driver. A small latency-accurate
//               ALU model sits on the ALU side. Stimulus pushes expected
//               responses into a queue; a monitor pops and compares on every
//               response handshake and checks response latency.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_alu_driver;

    localparam int DATA_W = 8;
    localparam int TAG_W  = 4;
    localparam int LAT    = 1;

    localparam logic [2:0] c_OP_ADD = 3'd0;
    localparam logic [2:0] c_OP_SUB = 3'd1;
    localparam logic [2:0] c_OP_AND = 3'd2;
    localparam logic [2:0] c_OP_OR  = 3'd3;
    localparam logic [2:0] c_OP_XOR = 3'd4;
    localparam logic [2:0] c_OP_NOT = 3'd5;
    localparam logic [2:0] c_OP_SHL = 3'd6;
    localparam logic [2:0] c_OP_SHR = 3'd7;

`ifdef ALU_DRV_ZERO_CHECK_EN
    localparam logic c_EXP_ERR = 1'b1;
`else
    localparam logic c_EXP_ERR = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_op;
    logic [DATA_W-1:0] cmd_a;
    logic [DATA_W-1:0] cmd_b;
    logic [TAG_W-1:0]  cmd_tag;
    logic [2:0]        alu_opcode;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_out;
    logic              alu_zero;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_zero;
    logic [TAG_W-1:0]  rsp_tag;
    logic              busy;
    logic [15:0]       done_count;
    logic              flag_err;

    logic              force_bad = 1'b0;

    always #5 clk = ~clk;

    alu_driver #(
        .DATA_W  (DATA_W),
        .TAG_W   (TAG_W),
        .ALU_LAT (LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .cmd_tag    (cmd_tag),
        .alu_opcode (alu_opcode),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_out    (alu_out),
        .alu_zero   (alu_zero),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_zero   (rsp_zero),
        .rsp_tag    (rsp_tag),
        .busy       (busy),
        .done_count (done_count),
        .flag_err   (flag_err)
    );

    //--------------------------------------------------------------------------
    // ALU model: LAT register stages; force_bad makes it report a nonzero
    // result with the zero flag set.
    //--------------------------------------------------------------------------
    function automatic logic [7:0] alu_f(logic [2:0] op, logic [7:0] a, logic [7:0] b);
        case (op)
            c_OP_ADD: return a + b;
            c_OP_SUB: return a - b;
            c_OP_AND: return a & b;
            c_OP_OR:  return a | b;
            c_OP_XOR: return a ^ b;
            c_OP_NOT: return ~a;
            c_OP_SHL: return a << 1;
            default:  return a >> 1;
        endcase
    endfunction

    logic [7:0] pipe [LAT];

    always @(posedge clk) begin
        pipe[0] <= alu_f(alu_opcode, alu_a, alu_b);
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end

    assign alu_out  = force_bad ? 8'h04 : pipe[LAT-1];
    assign alu_zero = force_bad ? 1'b1  : (pipe[LAT-1] == 8'h00);

    //--------------------------------------------------------------------------
    // Check bookkeeping
    //--------------------------------------------------------------------------
    int n_pass  = 0;
    int n_total = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    typedef struct {
        logic [7:0] d;
        logic       z;
        logic [3:0] t;
    } exp_t;

    exp_t sb_q [$];

    //--------------------------------------------------------------------------
    // Monitor: acceptance tracking, latency check, scoreboard compare
    //--------------------------------------------------------------------------
    int   cyc      = 0;
    int   last_acc = -1;
    logic prev_rv  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        exp_t e;
        // A handshake seen now completes on the next rising edge, cyc+1.
        if (!rst && cmd_valid && cmd_ready) last_acc = cyc + 1;
        if (rsp_valid === 1'b1 && prev_rv === 1'b0)
            check("rsp_latency", cyc - last_acc, LAT + 1);
        prev_rv = rsp_valid;
        if (!rst && rsp_valid && rsp_ready) begin
            if (sb_q.size() == 0) begin
                check("sb_underflow", sb_q.size(), 1);
            end else begin
                e = sb_q.pop_front();
                check("rsp_data", rsp_data, e.d);
                check("rsp_zero", rsp_zero, e.z);
                check("rsp_tag",  rsp_tag,  e.t);
            end
        end
    end

    //--------------------------------------------------------------------------
    // Stimulus helpers: all of them start and end 1 time unit after a rising
    // edge so inputs never change at the active edge.
    //--------------------------------------------------------------------------
    task automatic issue(logic [2:0] op, logic [7:0] a, logic [7:0] b, logic [3:0] tag,
                         bit push, logic [7:0] ed, logic ez);
        int n;
        if (push) sb_q.push_back('{d: ed, z: ez, t: tag});
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_tag   = tag;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("cmd_ready_before_accept", cmd_ready, 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", busy, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp();
        int n;
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rsp_valid_timeout", rsp_valid, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic check_reset_state(string tag);
        @(negedge clk);
        check({tag, "_rsp_valid"},  rsp_valid,  0);
        check({tag, "_busy"},       busy,       0);
        check({tag, "_cmd_ready"},  cmd_ready,  1);
        check({tag, "_rsp_data"},   rsp_data,   0);
        check({tag, "_rsp_zero"},   rsp_zero,   0);
        check({tag, "_rsp_tag"},    rsp_tag,    0);
        check({tag, "_alu_opcode"}, alu_opcode, c_OP_ADD);
        check({tag, "_alu_a"},      alu_a,      0);
        check({tag, "_alu_b"},      alu_b,      0);
        check({tag, "_done_count"}, done_count, 0);
        check({tag, "_flag_err"},   flag_err,   0);
        @(posedge clk);
        #1;
    endtask

    //--------------------------------------------------------------------------
    // Watchdog
    //--------------------------------------------------------------------------
    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    //--------------------------------------------------------------------------
    // Directed sequence
    //--------------------------------------------------------------------------
    initial begin
        int prev_acc;
        int acc;
        int n;

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = c_OP_ADD;
        cmd_a     = '0;
        cmd_b     = '0;
        cmd_tag   = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        check_reset_state("reset");

        // Basic operations, rsp_ready held high
        issue(c_OP_ADD, 8'h05, 8'h03, 4'h3, 1, 8'h08, 1'b0);
        wait_idle();
        check("add_done_count", done_count, 1);

        issue(c_OP_SUB, 8'h05, 8'h05, 4'h4, 1, 8'h00, 1'b1);
        wait_idle();
        check("sub_zero_done_count", done_count, 2);

        issue(c_OP_XOR, 8'hF0, 8'hFF, 4'h6, 1, 8'h0F, 1'b0);
        wait_idle();
        issue(c_OP_AND, 8'hCC, 8'h0F, 4'h2, 1, 8'h0C, 1'b0);
        wait_idle();
        check("and_done_count", done_count, 4);

        // Backpressure: hold the response for 5 cycles, with an ignored
        // command pulse in the middle of the stall
        rsp_ready = 1'b0;
        issue(c_OP_SUB, 8'h05, 8'h03, 4'h5, 1, 8'h02, 1'b0);
        wait_rsp();
        for (int k = 0; k < 5; k++) begin
            if (k == 1) begin
                cmd_valid = 1'b1;
                cmd_op    = c_OP_OR;
                cmd_a     = 8'hAA;
                cmd_b     = 8'h55;
                cmd_tag   = 4'hF;
            end
            if (k == 2) cmd_valid = 1'b0;
            @(negedge clk);
            check("bp_rsp_valid",  rsp_valid,  1);
            check("bp_rsp_data",   rsp_data,   8'h02);
            check("bp_cmd_ready",  cmd_ready,  0);
            check("bp_alu_a",      alu_a,      8'h05);
            check("bp_alu_b",      alu_b,      8'h03);
            check("bp_done_count", done_count, 4);
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_idle();
        repeat (2) @(posedge clk);
        #1;
        check("bp_done_after",   done_count, 5);
        check("bp_alu_a_after",  alu_a,      8'h05);
        check("bp_alu_op_after", alu_opcode, c_OP_SUB);

        // Back-to-back: ten commands with cmd_valid and rsp_ready held high
        pulse_rst();
        prev_acc  = 0;
        cmd_valid = 1'b1;
        rsp_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            sb_q.push_back('{d: 8'(8'h10 + 2 * k), z: 1'b0, t: 4'(k)});
            cmd_op  = c_OP_ADD;
            cmd_a   = 8'(8'h10 + k);
            cmd_b   = 8'(k);
            cmd_tag = 4'(k);
            n = 0;
            @(negedge clk);
            while (!cmd_ready && n < 50) begin
                @(negedge clk);
                n++;
            end
            check("b2b_ready", cmd_ready, 1);
            acc = cyc + 1;
            if (k > 0) check("b2b_spacing", acc - prev_acc, LAT + 3);
            prev_acc = acc;
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        wait_idle();
        check("b2b_done_count", done_count, 10);

        // Reset while waiting for the ALU
        issue(c_OP_ADD, 8'h20, 8'h22, 4'h9, 0, 8'h00, 1'b0);
        pulse_rst();
        check_reset_state("rst_wait");

        // Reset while holding a response
        rsp_ready = 1'b0;
        issue(c_OP_ADD, 8'h30, 8'h01, 4'hA, 0, 8'h00, 1'b0);
        wait_rsp();
        pulse_rst();
        rsp_ready = 1'b1;
        check_reset_state("rst_resp");

        // Reset together with a command: the command must not be accepted
        rst       = 1'b1;
        cmd_valid = 1'b1;
        cmd_op    = c_OP_SUB;
        cmd_a     = 8'h40;
        cmd_b     = 8'h01;
        cmd_tag   = 4'hB;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        cmd_valid = 1'b0;
        check_reset_state("rst_cmd");

        // Recovery after reset
        issue(c_OP_ADD, 8'h01, 8'h01, 4'h1, 1, 8'h02, 1'b0);
        wait_idle();
        check("recover_done_count", done_count, 1);

        // Zero-flag consistency: bad ALU flag, then a good op
        force_bad = 1'b1;
        issue(c_OP_ADD, 8'h02, 8'h02, 4'h7, 1, 8'h04, 1'b1);
        wait_idle();
        force_bad = 1'b0;
        check("zchk_flag_err", flag_err, c_EXP_ERR);
        issue(c_OP_ADD, 8'h03, 8'h04, 4'h8, 1, 8'h07, 1'b0);
        wait_idle();
        check("zchk_flag_sticky", flag_err, c_EXP_ERR);
        check("zchk_done_count", done_count, 3);
        pulse_rst();
        @(negedge clk);
        check("zchk_flag_cleared", flag_err, 0);

        check("sb_empty", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
